fifo_pair_adder: RTL and testbench
==================================

FIFO_PAIR_ADDER -- requirements
Module: fifo_pair_adder

Interface
REQ-001 Parameter: width, default 8, operand and sum width in bits (legal range 1..32).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 a_data  input  width  operand A, head entry of upstream FIFO A (combinational read side).
REQ-005 a_empty  input  1  FIFO A holds no entries.
REQ-006 a_pop  output  1  pops FIFO A this cycle.
REQ-007 b_data  input  width  operand B, head entry of upstream FIFO B.
REQ-008 b_empty  input  1  FIFO B holds no entries.
REQ-009 b_pop  output  1  pops FIFO B this cycle.
REQ-010 sum_valid  output  1  sum_data holds a valid result.
REQ-011 sum_ready  input  1  downstream accepts sum_data this cycle.
REQ-012 sum_data  output  width  result, head of internal output buffer.
REQ-013 ovf  output  1  sideband flag travelling with sum_data: carry out of the add.

Function
REQ-014 Internal output buffer: 2 entries, each {sum, ovf}; occupancy count 0..2.
REQ-015 Transfer out = sum_valid & sum_ready; sum_valid = (count != 0).
REQ-016 Space = (count < 2) | transfer out.
REQ-017 Fire = !a_empty & !b_empty & space.
REQ-018 a_pop = b_pop = fire; operands always consumed as a pair, never one alone.
REQ-019 On fire, {ovf, sum} = a_data + b_data, computed at width+1 bits, written into the buffer at the tail on the same edge.
REQ-020 Latency: operands popped in cycle N appear on sum_data/sum_valid in cycle N+1 when the buffer was empty.
REQ-021 Throughput: one result per cycle sustained while both FIFOs are non-empty and sum_ready = 1.
REQ-022 Buffer is in-order: results leave in pop order; a simultaneous fire and transfer out leaves count unchanged.
REQ-023 count = 2 with sum_ready = 0: fire = 0, no pops, sum_data and ovf held stable.
REQ-024 sum_data and ovf are stable while sum_valid & !sum_ready (AXI-style hold rule).
REQ-025 Buffer read/write pointers are 1 bit wide and wrap modulo 2.
REQ-026 a_pop and b_pop are combinational from the inputs and count; sum_data, ovf and sum_valid come from registers only.

Reset
REQ-027 rst clears count and both pointers; sum_valid = 0 and a_pop = b_pop = 0 while rst is high.
REQ-028 Buffer data entries are not reset; sum_data is don't-care while sum_valid = 0.
REQ-029 rst asserted mid-operation discards all buffered results immediately (asynchronous); no pop occurs in a cycle where rst is high.

Configuration
REQ-030 Macro FIFO_PAIR_ADDER_SAT_EN defined: unsigned saturating add; on carry out, sum = all-ones and ovf = 1.
REQ-031 Macro FIFO_PAIR_ADDER_SAT_EN undefined: wrap-around add; sum = low width bits and ovf = carry out.
REQ-032 The macro changes only the stored sum value; timing, handshake and ovf semantics are identical in both builds.

Structure
REQ-033 Shared package fifo_pair_adder_pkg holds the default width constant and the buffer entry struct typedef {ovf, sum}.
REQ-034 Sub-module two_entry_out_buffer, parameterized by entry width, implements REQ-014..REQ-016, REQ-022..REQ-025 (push/valid/ready/count); the adder datapath and fire logic live in the top.

Verification (width = 8)
REQ-035 Reset release, both FIFOs empty -> sum_valid = 0 and a_pop = b_pop = 0 for 10 cycles.
REQ-036 A = 3, B = 4 pushed, sum_ready = 1 -> single pop pair; next cycle sum_data = 7, ovf = 0, sum_valid = 1 for exactly one cycle.
REQ-037 A = 200, B = 100 -> wrap build: sum_data = 44, ovf = 1; SAT_EN build: sum_data = 255, ovf = 1.
REQ-038 Ten pairs queued, sum_ready = 0 -> exactly 2 pops, then stall with sum_data held; raising sum_ready drains all ten results in order, one per cycle.
REQ-039 Only A non-empty for 5 cycles, then B filled -> no pops during the 5 cycles, then paired pops; A is never popped alone.
REQ-040 rst pulsed with count = 2 -> sum_valid drops in the same cycle; after release, new pair 1 + 1 yields sum_data = 2 with no stale data emitted.

Source files
------------

// File: rtl/fifo_pair_adder_pkg.sv
// Shared constants and payload types for the fifo_pair_adder block.
package fifo_pair_adder_pkg;

  // Default operand/sum width in bits.
  localparam int unsigned DEF_WIDTH = 8;

  // Output buffer entry at the default width: carry/saturation flag plus sum.
  typedef struct packed {
    logic                 ovf;
    logic [DEF_WIDTH-1:0] sum;
  } buf_entry_t;

endpackage : fifo_pair_adder_pkg

// File: rtl/fifo_pair_adder_out_buffer.sv
// Two-entry in-order output buffer with valid/ready read side.
// The caller pushes only when space_c is high. out_valid and out_data are
// driven from registers only; space_c is combinational.
module two_entry_out_buffer #(
  parameter int unsigned ENTRY_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  output logic               space_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data
);

  localparam int unsigned DEPTH = 2;

  logic [1:0]         r_count;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic               w_xfer;

  assign out_valid = (r_count != 2'd0);
  assign w_xfer    = out_valid & out_ready;
  assign space_c   = (r_count < 2'd2) | w_xfer;
  assign out_data  = r_mem[r_rd_ptr];

  // Occupancy and 1-bit wrapping pointers; cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (push)   r_wr_ptr <= ~r_wr_ptr;
      if (w_xfer) r_rd_ptr <= ~r_rd_ptr;
      case ({push, w_xfer})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; data is don't-care while the buffer is empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule : two_entry_out_buffer

// File: rtl/fifo_pair_adder.sv
// Pops one operand from each of two upstream FIFOs as a pair, adds them and
// queues {ovf, sum} in a two-entry output buffer.
// Build option: define FIFO_PAIR_ADDER_SAT_EN for an unsigned saturating add;
// otherwise the add wraps. ovf is the carry out in both builds.
module fifo_pair_adder
  import fifo_pair_adder_pkg::*;
#(
  parameter int unsigned width = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] a_data,
  input  logic             a_empty,
  output logic             a_pop,
  input  logic [width-1:0] b_data,
  input  logic             b_empty,
  output logic             b_pop,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [width-1:0] sum_data,
  output logic             ovf
);

  localparam int unsigned ENTRY_W = width + 1;

  logic [ENTRY_W-1:0] w_sum_full;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_out_entry;
  logic               w_space;
  logic               w_fire;

  assign w_sum_full = {1'b0, a_data} + {1'b0, b_data};

`ifdef FIFO_PAIR_ADDER_SAT_EN
  // Clamp to all-ones on carry out; the flag still reports the carry.
  assign w_entry = w_sum_full[width] ? {1'b1, {width{1'b1}}} : w_sum_full;
`else
  assign w_entry = w_sum_full;
`endif

  // Operands are consumed strictly as a pair, and never while in reset.
  assign w_fire = ~rst & ~a_empty & ~b_empty & w_space;
  assign a_pop  = w_fire;
  assign b_pop  = w_fire;

  two_entry_out_buffer #(
    .ENTRY_W (ENTRY_W)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (w_fire),
    .push_data (w_entry),
    .space_c   (w_space),
    .out_valid (sum_valid),
    .out_ready (sum_ready),
    .out_data  (w_out_entry)
  );

  assign sum_data = w_out_entry[width-1:0];
  assign ovf      = w_out_entry[width];

endmodule : fifo_pair_adder

// File: tb/tb_fifo_pair_adder.sv
// Directed bench for fifo_pair_adder at width 8, with queue-modelled upstream
// FIFOs and an in-order result scoreboard.
module tb_fifo_pair_adder;
  import fifo_pair_adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data;
  logic       a_empty, b_empty;
  logic       a_pop, b_pop;
  logic       sum_valid, sum_ready;
  logic [7:0] sum_data;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa [$];
  logic [7:0] qb [$];
  buf_entry_t exp_q [$];
  int n_pops  = 0;
  int n_xfers = 0;

  fifo_pair_adder #(.width(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_data    (a_data),
    .a_empty   (a_empty),
    .a_pop     (a_pop),
    .b_data    (b_data),
    .b_empty   (b_empty),
    .b_pop     (b_pop),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic buf_entry_t exp_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef FIFO_PAIR_ADDER_SAT_EN
    if (s[8]) s = 9'h1FF;
`endif
    return buf_entry_t'(s);
  endfunction

  task automatic drive_inputs();
    a_empty = (qa.size() == 0);
    b_empty = (qb.size() == 0);
    a_data  = (qa.size() != 0) ? qa[0] : 8'd0;
    b_data  = (qb.size() != 0) ? qb[0] : 8'd0;
  endtask

  // One clock: sample handshakes before the edge, update models after it.
  task automatic step();
    logic pa, pb;
    buf_entry_t e;
    @(negedge clk);
    pa = a_pop;
    pb = b_pop;
    check("pop_pair", 32'(pa), 32'(pb));
    if (sum_valid && sum_ready) begin
      n_xfers++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_sum", 32'(sum_data), 32'(e.sum));
        check("out_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
    if (pa && pb) begin
      n_pops++;
      exp_q.push_back(exp_add(qa[0], qb[0]));
    end
    @(posedge clk);
    #1;
    if (pa && qa.size() != 0) void'(qa.pop_front());
    if (pb && qb.size() != 0) void'(qb.pop_front());
    drive_inputs();
    #1;
  endtask

  logic [7:0] held;

  initial begin
    rst = 1'b1;
    sum_ready = 1'b1;
    qa.push_back(8'd9);
    qb.push_back(8'd9);
    drive_inputs();
    #12;
    // Reset: nothing valid and no pops even with operands available.
    check("rst_valid", 32'(sum_valid), 32'(0));
    check("rst_pop", 32'(a_pop), 32'(0));
    qa.delete();
    qb.delete();
    drive_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Idle with both FIFOs empty.
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_valid", 32'(sum_valid), 32'(0));
      check("idle_pop", 32'(a_pop | b_pop), 32'(0));
    end

    // 3 + 4, one-cycle latency, single result.
    qa.push_back(8'd3);
    qb.push_back(8'd4);
    drive_inputs();
    #1;
    check("p34_pop", 32'(a_pop), 32'(1));
    step();
    check("p34_valid", 32'(sum_valid), 32'(1));
    check("p34_sum", 32'(sum_data), 32'(7));
    check("p34_ovf", 32'(ovf), 32'(0));
    check("p34_nopop", 32'(a_pop), 32'(0));
    step();
    check("p34_once", 32'(sum_valid), 32'(0));

    // 200 + 100 overflows.
    qa.push_back(8'd200);
    qb.push_back(8'd100);
    drive_inputs();
    step();
`ifdef FIFO_PAIR_ADDER_SAT_EN
    check("ovf_sum", 32'(sum_data), 32'(255));
`else
    check("ovf_sum", 32'(sum_data), 32'(44));
`endif
    check("ovf_flag", 32'(ovf), 32'(1));
    step();

    // Ten pairs with backpressure: two pops then stall, then drain in order.
    sum_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      qa.push_back(8'(i * 25));
      qb.push_back(8'(i * 3 + 1));
    end
    drive_inputs();
    n_pops = 0;
    step();
    held = sum_data;
    check("stall_first", 32'(held), 32'(1));
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold", 32'(sum_data), 32'(held));
      check("stall_valid", 32'(sum_valid), 32'(1));
    end
    check("stall_pops", 32'(n_pops), 32'(2));
    sum_ready = 1'b1;
    n_xfers = 0;
    for (int i = 0; i < 10; i++) step();
    check("drain_xfers", 32'(n_xfers), 32'(10));
    check("drain_empty", 32'(exp_q.size()), 32'(0));
    check("drain_valid", 32'(sum_valid), 32'(0));

    // Only A non-empty: no pops until B arrives.
    n_pops = 0;
    for (int i = 0; i < 3; i++) qa.push_back(8'(10 + i));
    drive_inputs();
    for (int i = 0; i < 5; i++) begin
      step();
      check("aonly_pop", 32'(a_pop | b_pop), 32'(0));
    end
    for (int i = 0; i < 3; i++) qb.push_back(8'(20 + i));
    drive_inputs();
    for (int i = 0; i < 6; i++) step();
    check("aonly_pairs", 32'(n_pops), 32'(3));
    check("aonly_qa", 32'(qa.size()), 32'(0));
    check("aonly_exp", 32'(exp_q.size()), 32'(0));

    // Reset while full discards results at once.
    sum_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      qa.push_back(8'(50 + i));
      qb.push_back(8'(60 + i));
    end
    drive_inputs();
    for (int i = 0; i < 3; i++) step();
    check("full_valid", 32'(sum_valid), 32'(1));
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(sum_valid), 32'(0));
    check("rst_mid_pop", 32'(a_pop), 32'(0));
    exp_q.delete();
    qa.delete();
    qb.delete();
    drive_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    sum_ready = 1'b1;
    qa.push_back(8'd1);
    qb.push_back(8'd1);
    drive_inputs();
    #1;
    check("post_rst_idle", 32'(sum_valid), 32'(0));
    step();
    check("post_rst_valid", 32'(sum_valid), 32'(1));
    check("post_rst_sum", 32'(sum_data), 32'(2));
    step();
    check("post_rst_done", 32'(sum_valid), 32'(0));
    check("post_rst_exp", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fifo_pair_adder
